// File: rtl/cmd_fifo_sequencer.sv
// Command sequencer: loads RX bytes into a FIFO, dumps them to TX, clears it.
// Ports: cmd_vld/cmd/len command strobe; rx_vld/rx_data byte input;
//        tx_vld/tx_data/tx_rdy FWFT output stream; done_ack releases DONE;
//        busy/done/err/fifo_cnt status. Macro CMD_FIFO_SEQUENCER_TIMEOUT_EN
//        adds an RX inter-byte timeout in LOAD (err[2]).
module cmd_fifo_sequencer #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 16,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_vld,
    input  logic [7:0]               cmd,
    input  logic [CNT_W-1:0]         len,
    input  logic                     rx_vld,
    input  logic [DATA_W-1:0]        rx_data,
    output logic                     tx_vld,
    output logic [DATA_W-1:0]        tx_data,
    input  logic                     tx_rdy,
    input  logic                     done_ack,
    output logic                     busy,
    output logic                     done,
    output logic [2:0]               err,
    output logic [$clog2(DEPTH):0]   fifo_cnt
);

    localparam int AW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((1 << AW) != DEPTH) || (TIMEOUT_CYC < 1)) begin : g_bad_param
        $error("cmd_fifo_sequencer: bad DEPTH or TIMEOUT_CYC");
    end

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]  len_cnt_q, len_cnt_d;
    logic              echo_q, echo_d;
    logic [1:0]        err_q, err_d;
    logic              push, pop;
    logic              fifo_empty, fifo_full;
    logic [DATA_W-1:0] mem_q [DEPTH];

`ifdef CMD_FIFO_SEQUENCER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmr_q, tmr_d;
    logic          to_q, to_d;
`endif

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == (AW+1)'(DEPTH));

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        len_cnt_d = len_cnt_q;
        echo_d    = echo_q;
        err_d     = err_q;
        push      = 1'b0;
        pop       = 1'b0;
`ifdef CMD_FIFO_SEQUENCER_TIMEOUT_EN
        tmr_d     = tmr_q;
        to_d      = to_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_vld) begin
                    err_d = '0;
`ifdef CMD_FIFO_SEQUENCER_TIMEOUT_EN
                    to_d  = 1'b0;
                    tmr_d = '0;
`endif
                    case (cmd)
                        8'h01, 8'h06: begin
                            len_cnt_d = len;
                            echo_d    = (cmd == 8'h01);
                            state_d   = LOAD;
                        end
                        8'h05: state_d = SEND;
                        8'h07: begin
                            wr_ptr_d = '0;
                            rd_ptr_d = '0;
                            cnt_d    = '0;
                            state_d  = DONE;
                        end
                        default: begin
                            err_d[1] = 1'b1;
                            state_d  = DONE;
                        end
                    endcase
                end
            end
            LOAD: begin
                if (len_cnt_q == '0) begin
                    state_d = echo_q ? SEND : DONE;
                end else if (rx_vld) begin
                    // Dropped bytes still consume length so LOAD terminates.
                    len_cnt_d = len_cnt_q - CNT_W'(1);
`ifdef CMD_FIFO_SEQUENCER_TIMEOUT_EN
                    tmr_d = '0;
`endif
                    if (!fifo_full) push = 1'b1;
                    else            err_d[0] = 1'b1;
                end
`ifdef CMD_FIFO_SEQUENCER_TIMEOUT_EN
                else if (tmr_q == TW'(TIMEOUT_CYC - 1)) begin
                    to_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
`endif
            end
            SEND: begin
                if (fifo_empty)  state_d = DONE;
                else if (tx_rdy) pop = 1'b1;
            end
            DONE: begin
                if (done_ack) state_d = IDLE;
            end
        endcase

        // push and pop live in disjoint states, never both in one cycle
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            cnt_d    = cnt_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d    = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            len_cnt_q <= '0;
            echo_q    <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            len_cnt_q <= len_cnt_d;
            echo_q    <= echo_d;
            err_q     <= err_d;
        end
    end

`ifdef CMD_FIFO_SEQUENCER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= '0;
            to_q  <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            to_q  <= to_d;
        end
    end
    assign err = {to_q, err_q};
`else
    assign err = {1'b0, err_q};
`endif

    // Storage needs no reset; push is low whenever state is held in reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_data;
    end

    assign tx_vld   = (state_q == SEND) && !fifo_empty;
    assign tx_data  = mem_q[rd_ptr_q];
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign fifo_cnt = cnt_q;

endmodule

// File: tb/tb_cmd_fifo_sequencer.sv
// Self-checking bench for cmd_fifo_sequencer (DEPTH=16, TIMEOUT_CYC=100).
// Expected TX words are queued at stimulus time and matched against transfers.
module tb_cmd_fifo_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_vld = 1'b0;
    logic [7:0]  cmd = '0;
    logic [15:0] len = '0;
    logic        rx_vld = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        tx_vld;
    logic [7:0]  tx_data;
    logic        tx_rdy = 1'b0;
    logic        done_ack = 1'b0;
    logic        busy;
    logic        done;
    logic [2:0]  err;
    logic [4:0]  fifo_cnt;

    int checks = 0;
    int errors = 0;
    int stall_viol = 0;
    logic [7:0] exp_q [$];
    logic [7:0] obs_q [$];
    logic       hold_vld = 1'b0;
    logic [7:0] hold_data = '0;

    cmd_fifo_sequencer #(
        .DATA_W(8), .DEPTH(16), .CNT_W(16), .TIMEOUT_CYC(100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd(cmd), .len(len),
        .rx_vld(rx_vld), .rx_data(rx_data), .tx_vld(tx_vld), .tx_data(tx_data),
        .tx_rdy(tx_rdy), .done_ack(done_ack), .busy(busy), .done(done),
        .err(err), .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change #1 after posedge, so negedge values hold through the next edge.
    always @(negedge clk) begin
        if (rst_n && tx_vld && tx_rdy) obs_q.push_back(tx_data);
        if (rst_n && tx_vld && hold_vld && (tx_data !== hold_data))
            stall_viol <= stall_viol + 1;
        hold_vld  <= rst_n && tx_vld && !tx_rdy;
        hold_data <= tx_data;
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [7:0] c, input logic [15:0] l);
        cmd_vld = 1'b1;
        cmd = c;
        len = l;
        tick();
        cmd_vld = 1'b0;
    endtask

    task automatic rx(input logic [7:0] b);
        rx_vld = 1'b1;
        rx_data = b;
        tick();
        rx_vld = 1'b0;
    endtask

    task automatic ack();
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk(tag, done, 1'b1);
    endtask

    task automatic cmp_stream(input string tag);
        while (exp_q.size() > 0) begin
            if (obs_q.size() == 0) begin
                chk({tag, "_missing"}, exp_q.size(), 0);
                exp_q.delete();
            end else begin
                chk(tag, obs_q.pop_front(), exp_q.pop_front());
            end
        end
        chk({tag, "_extra"}, obs_q.size(), 0);
        obs_q.delete();
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt", fifo_cnt, 0);
        chk("rst_txvld", tx_vld, 0);
        rst_n = 1'b1;
        tick();

        // load+echo 3 bytes
        tx_rdy = 1'b1;
        do_cmd(8'h01, 16'd3);
        chk("t1_busy", busy, 1);
        rx(8'hA1); exp_q.push_back(8'hA1);
        rx(8'hB2); exp_q.push_back(8'hB2);
        rx(8'hC3); exp_q.push_back(8'hC3);
        wait_done("t1_done", 20);
        chk("t1_err", err, 3'b000);
        chk("t1_cnt", fifo_cnt, 0);
        cmp_stream("t1_tx");
        ack();
        chk("t1_idle", busy, 0);

        // overflow: 18 bytes into 16 entries, then dump
        do_cmd(8'h06, 16'd18);
        for (int i = 0; i < 18; i++) begin
            rx(8'h10 + 8'(i));
            if (i < 16) exp_q.push_back(8'h10 + 8'(i));
        end
        wait_done("t2_done", 10);
        chk("t2_cnt", fifo_cnt, 16);
        chk("t2_err", err, 3'b001);
        ack();
        do_cmd(8'h05, 16'd0);
        chk("t2_err_clr", err, 3'b000);
        wait_done("t2_dump_done", 40);
        cmp_stream("t2_tx");
        chk("t2_cnt_end", fifo_cnt, 0);
        ack();

        // tx_rdy toggling with stall stability
        tx_rdy = 1'b0;
        do_cmd(8'h01, 16'd4);
        for (int i = 0; i < 4; i++) begin
            rx(8'h5A ^ 8'(i * 17));
            exp_q.push_back(8'h5A ^ 8'(i * 17));
        end
        begin
            int n = 0;
            while (!done && n < 100) begin
                tx_rdy = ~tx_rdy;
                tick();
                n++;
            end
        end
        chk("t3_done", done, 1);
        cmp_stream("t3_tx");
        chk("t3_stall", stall_viol, 0);
        ack();

        // bad command
        do_cmd(8'h3C, 16'd0);
        chk("t4_bad_done", done, 1);
        chk("t4_bad_err", err, 3'b010);
        ack();

        // rx outside LOAD is ignored
        rx(8'hEE);
        tick();
        chk("t4_rx_idle", fifo_cnt, 0);

        // clear with 5 stored
        do_cmd(8'h06, 16'd5);
        for (int i = 0; i < 5; i++) rx(8'h30 + 8'(i));
        wait_done("t4_load_done", 10);
        chk("t4_cnt5", fifo_cnt, 5);
        ack();
        do_cmd(8'h07, 16'd0);
        chk("t4_clr_cnt", fifo_cnt, 0);
        chk("t4_clr_done", done, 1);

        // cmd in DONE is ignored
        do_cmd(8'h05, 16'd0);
        chk("t4_cmd_ign", done, 1);
        ack();

        // len=0 echo: straight through SEND with nothing to send
        tx_rdy = 1'b1;
        do_cmd(8'h01, 16'd0);
        wait_done("t5_len0", 10);
        chk("t5_len0_tx", obs_q.size(), 0);
        chk("t5_len0_err", err, 0);
        ack();

`ifdef CMD_FIFO_SEQUENCER_TIMEOUT_EN
        do_cmd(8'h06, 16'd5);
        rx(8'h71);
        rx(8'h72);
        repeat (90) tick();
        chk("t6_early", done, 0);
        wait_done("t6_to_done", 20);
        chk("t6_err", err[2], 1);
        chk("t6_cnt", fifo_cnt, 2);
        ack();
        do_cmd(8'h07, 16'd0);
        ack();
`endif

        // reset mid-SEND after 2 of 6 words
        tx_rdy = 1'b0;
        do_cmd(8'h06, 16'd6);
        for (int i = 0; i < 6; i++) begin
            rx(8'h90 + 8'(i));
            exp_q.push_back(8'h90 + 8'(i));
        end
        wait_done("t7_load", 10);
        ack();
        do_cmd(8'h05, 16'd0);
        tx_rdy = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t7_txvld", tx_vld, 0);
        chk("t7_busy", busy, 0);
        chk("t7_done", done, 0);
        chk("t7_cnt", fifo_cnt, 0);
        chk("t7_err", err, 0);
        chk("t7_nxfer", obs_q.size(), 2);
        while (exp_q.size() > 4) begin
            if (obs_q.size() == 0) begin
                chk("t7_missing", 1, 0);
                exp_q.delete();
            end else begin
                chk("t7_tx", obs_q.pop_front(), exp_q.pop_front());
            end
        end
        exp_q.delete();
        obs_q.delete();
        tick();
        tick();
        chk("t7_hold_txvld", tx_vld, 0);
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_fifo_sequencer.md
CMD_FIFO_SEQUENCER -- requirements
Module: cmd_fifo_sequencer

Interface
REQ-001 Parameter DATA_W, default 8, FIFO/RX/TX data width.
REQ-002 Parameter DEPTH, default 16, FIFO entries, power of two, at least 2.
REQ-003 Parameter CNT_W, default 16, width of the load length counter.
REQ-004 Parameter TIMEOUT_CYC, default 50000, RX inter-byte timeout in clk cycles.
REQ-005 clk  in  1  single system clock, all logic on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 cmd_vld  in  1  one-cycle command strobe.
REQ-008 cmd  in  8  command code, sampled when cmd_vld=1.
REQ-009 len  in  CNT_W  byte count for load commands, sampled with cmd.
REQ-010 rx_vld  in  1  one-cycle strobe marking a received byte.
REQ-011 rx_data  in  DATA_W  received byte.
REQ-012 tx_vld  out  1  TX word valid.
REQ-013 tx_data  out  DATA_W  TX word.
REQ-014 tx_rdy  in  1  TX sink ready; a transfer occurs when tx_vld=1 and tx_rdy=1.
REQ-015 done_ack  in  1  one-cycle strobe that releases the DONE state.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 done  out  1  high while state is DONE.
REQ-018 err  out  3  sticky status: bit0 overflow, bit1 bad command, bit2 timeout.
REQ-019 fifo_cnt  out  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

Function
REQ-020 States SHALL be IDLE, LOAD, SEND, DONE.
REQ-021 In IDLE, cmd_vld=1 SHALL clear err and select the next state from cmd; busy SHALL rise on the following cycle.
REQ-022 Command 0x01 (load+echo) and 0x06 (load only) SHALL load len into the counter and enter LOAD.
REQ-023 Command 0x05 (dump) SHALL enter SEND. Command 0x07 (clear) SHALL empty the FIFO in one cycle and enter DONE.
REQ-024 Any other command SHALL set err[1] and enter DONE.
REQ-025 cmd_vld outside IDLE SHALL be ignored.
REQ-026 In LOAD, each rx_vld with counter>0 SHALL decrement the counter. If the FIFO is not full, it SHALL push rx_data and fifo_cnt SHALL update on the next cycle.
REQ-027 A byte arriving while the FIFO is full SHALL be dropped, set err[0], and still decrement the counter.
REQ-028 When the counter is 0 (including len=0), LOAD SHALL exit on the next cycle: to SEND for 0x01, to DONE for 0x06.
REQ-029 rx_vld outside LOAD SHALL be ignored.
REQ-030 In SEND, tx_vld SHALL equal !fifo_empty, and tx_data SHALL be the FIFO head (first-word fall-through); each transfer SHALL pop one word.
REQ-031 SEND SHALL enter DONE on the cycle after the FIFO becomes empty. tx_data SHALL be held stable while tx_vld=1 and tx_rdy=0.
REQ-032 DONE SHALL hold until done_ack=1, then return to IDLE. done_ack in other states SHALL be ignored.
REQ-033 FIFO pointers SHALL wrap modulo DEPTH. FIFO contents SHALL persist across commands except for clear.

Reset
REQ-034 While rst_n=0: state IDLE, FIFO empty, counter 0, err 0, tx_vld 0, busy 0, done 0, fifo_cnt 0.
REQ-035 Reset asserted mid-LOAD or mid-SEND SHALL abort immediately with no further pushes or pops.

Configuration
REQ-036 With macro CMD_FIFO_SEQUENCER_TIMEOUT_EN defined: in LOAD, a timer SHALL clear on entry and on each rx_vld. Reaching TIMEOUT_CYC SHALL set err[2] and enter DONE, keeping the bytes already loaded.
REQ-037 With the macro undefined: no timer logic SHALL exist, LOAD SHALL wait indefinitely, and err[2] SHALL be constant 0.

Verification
REQ-038 Command 0x01, len=3, rx bytes A1,B2,C3, tx_rdy=1 -> tx sequence A1,B2,C3, then done=1, err=000, fifo_cnt=0.
REQ-039 DEPTH=16, command 0x06, len=18 -> fifo_cnt=16, err[0]=1, DONE; then done_ack followed by command 0x05 -> first 16 bytes out in order.
REQ-040 Command 0x01, len=4, with tx_rdy toggling 1/0 each cycle -> 4 words transferred, no duplicates, tx_data stable while stalled.
REQ-041 Command 0x3C -> err=010, done=1 one cycle later; command 0x07 with fifo_cnt=5 -> fifo_cnt=0, DONE.
REQ-042 With the macro defined and TIMEOUT_CYC=100, command 0x06, len=5, only 2 bytes sent -> err[2]=1 and DONE after 100 idle cycles, fifo_cnt=2.
REQ-043 rst_n pulsed low mid-SEND after 2 of 6 words -> all outputs at reset values, tx_vld=0 immediately.
